// File: rtl/lion_mem_pkg.sv
// Shared types and helpers for the Lion memory-bus responder.
// The fault predicate is here so the FSM and any harness use the same rule.
package lion_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACC0,
        ACC1,
        RESP
    } state_t;

    localparam int WORD_BYTES = 4;

    // off is the request address relative to the window base.
    // A halfword-offset read of the last word would need word 0 next; that is rejected.
    function automatic logic req_faults(input logic [31:0] off,
                                        input logic        is_write,
                                        input int          depth_log2);
        logic [31:0] window;
        logic [31:0] last_word;
        window    = 32'(WORD_BYTES) << depth_log2;
        last_word = (window >> 2) - 32'd1;
        return (off >= window) || off[0] || (is_write && off[1]) ||
               (!is_write && off[1] && ((off >> 2) == last_word));
    endfunction

endpackage

// File: rtl/lion_mem_ram.sv
// Single-port word RAM with per-byte write enables and one-cycle read latency.
module lion_mem_ram
    import lion_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clock,
    input  logic                  en,
    input  logic [3:0]            we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [1<<DEPTH_LOG2];

    always_ff @(posedge clock) begin
        if (en) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (we[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/lion_mem_responder.sv
// Lion native-bus memory responder: wait states, byte-strobe writes and
// halfword-offset reads built from two consecutive word reads.
//
// state | meaning
// IDLE  | backdoor load or accept a bus request
// WAIT  | counting configured stall cycles
// ACC0  | commit write, or read word A
// ACC1  | keep upper half of word A, read word A+1
// RESP  | one-cycle mem_ready pulse
module lion_mem_responder
    import lion_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mem_valid,
    input  logic                  mem_instr,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_wstrb,
    output logic                  mem_ready,
    output logic [31:0]           mem_rdata,
    output logic                  mem_fault,
    input  logic                  ld_valid,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [31:0]           ld_data
);

    state_t                  state, state_nxt;
    logic [3:0]              cnt;
    logic [DEPTH_LOG2-1:0]   req_idx;
    logic [31:0]             req_wdata;
    logic [3:0]              req_wstrb;
    logic                    req_hi;
    logic                    req_fault;
    logic [15:0]             lo_half;
    logic [31:0]             off;

    logic                    ram_en;
    logic [3:0]              ram_we;
    logic [DEPTH_LOG2-1:0]   ram_addr;
    logic [31:0]             ram_wdata;
    logic [31:0]             ram_rdata;

    // Fetch vs data makes no difference to timing or data.
    logic unused_instr;
    assign unused_instr = mem_instr;

    assign off = mem_addr - BASE_ADDR;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_idx   <= '0;
            req_wdata <= '0;
            req_wstrb <= '0;
            req_hi    <= 1'b0;
            req_fault <= 1'b0;
            lo_half   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (!ld_valid && mem_valid) begin
                        req_idx   <= off[DEPTH_LOG2+1:2];
                        req_wdata <= mem_wdata;
                        req_wstrb <= mem_wstrb;
                        req_hi    <= off[1];
                        req_fault <= req_faults(off, |mem_wstrb, DEPTH_LOG2);
                        cnt       <= 4'(WAIT_CYCLES);
                    end
                end
                WAIT:    cnt     <= cnt - 4'd1;
                ACC1:    lo_half <= ram_rdata[31:16];
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        ram_en    = 1'b0;
        ram_we    = 4'h0;
        ram_addr  = req_idx;
        ram_wdata = req_wdata;
        case (state)
            IDLE: begin
                if (ld_valid) begin
                    ram_en    = 1'b1;
                    ram_we    = 4'hF;
                    ram_addr  = ld_addr;
                    ram_wdata = ld_data;
                end else if (mem_valid) begin
                    state_nxt = (WAIT_CYCLES == 0) ? ACC0 : WAIT;
                end
            end
            WAIT: begin
                if (cnt <= 4'd1) state_nxt = ACC0;
            end
            ACC0: begin
                if (req_fault) begin
                    state_nxt = RESP;
                end else if (req_wstrb != 4'h0) begin
                    ram_en    = 1'b1;
                    ram_we    = req_wstrb;
                    state_nxt = RESP;
                end else begin
                    ram_en    = 1'b1;
                    state_nxt = req_hi ? ACC1 : RESP;
                end
            end
            ACC1: begin
                ram_en    = 1'b1;
                ram_addr  = req_idx + 1'b1;
                state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_ready = (state == RESP);
    assign mem_fault = mem_ready && req_fault;

    always_comb begin
        mem_rdata = '0;
        if (mem_ready && !req_fault && req_wstrb == 4'h0) begin
            mem_rdata = req_hi ? {ram_rdata[15:0], lo_half} : ram_rdata;
        end
    end

    lion_mem_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clock (clock),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_lion_mem_responder.sv
// Scoreboard bench for lion_mem_responder: one instance with no wait states
// and one with three, each checked against a shadow memory model.
module tb_lion_mem_responder;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int DL2 = 10;
    localparam int NW  = 1 << DL2;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          start;
        int          lat;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  valid, instr, ready, fault, ld_valid;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [3:0]  wstrb [2];
    logic [31:0] rdata [2];
    logic [9:0]  ld_addr [2];
    logic [31:0] ld_data [2];

    logic [31:0] shadow [2][NW];
    exp_t        q0[$], q1[$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    lion_mem_responder #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL2), .WAIT_CYCLES(0)) dut0 (
        .clock(clock), .reset(reset),
        .mem_valid(valid[0]), .mem_instr(instr[0]), .mem_addr(addr[0]),
        .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]),
        .mem_ready(ready[0]), .mem_rdata(rdata[0]), .mem_fault(fault[0]),
        .ld_valid(ld_valid[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0])
    );

    lion_mem_responder #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL2), .WAIT_CYCLES(3)) dut3 (
        .clock(clock), .reset(reset),
        .mem_valid(valid[1]), .mem_instr(instr[1]), .mem_addr(addr[1]),
        .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]),
        .mem_ready(ready[1]), .mem_rdata(rdata[1]), .mem_fault(fault[1]),
        .ld_valid(ld_valid[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1])
    );

    function automatic int waits(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin : mon
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (ready[i] === 1'b1) begin
                if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                    check_eq($sformatf("unexpected_ready_%0d", i), {31'b0, ready[i]}, 32'd0);
                end else begin
                    if (i == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    check_eq($sformatf("rdata_%0d", i), rdata[i], e.rdata);
                    check_eq($sformatf("fault_%0d", i), {31'b0, fault[i]}, {31'b0, e.fault});
                    check_eq($sformatf("latency_%0d", i), cyc - e.start, e.lat);
                end
            end
        end
    end

    task automatic preload(input int i, input int idx, input logic [31:0] d);
        @(negedge clock);
        ld_valid[i] = 1'b1;
        ld_addr[i]  = 10'(idx);
        ld_data[i]  = d;
        shadow[i][idx] = d;
        @(negedge clock);
        ld_valid[i] = 1'b0;
    endtask

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input logic ins, input bit track);
        exp_t        e;
        logic [31:0] o;
        logic        wr;
        int          idx;
        @(negedge clock);
        valid[i] = 1'b1;
        instr[i] = ins;
        addr[i]  = a;
        wdata[i] = wd;
        wstrb[i] = ws;
        o   = a - BASE;
        wr  = (ws != 4'h0);
        idx = int'(o >> 2);
        e.fault = (o >= 32'(4 * NW)) || a[0] || (wr && a[1]) ||
                  (!wr && a[1] && idx == NW - 1);
        e.start = cyc;
        e.lat   = (!e.fault && !wr && a[1]) ? 3 + waits(i) : 2 + waits(i);
        e.rdata = 32'h0;
        if (!e.fault && track) begin
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (ws[b]) shadow[i][idx][8*b +: 8] = wd[8*b +: 8];
            end else if (a[1]) begin
                e.rdata = {shadow[i][idx+1][15:0], shadow[i][idx][31:16]};
            end else begin
                e.rdata = shadow[i][idx];
            end
        end
        if (track) begin
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic finish_req(input int i, output int at, output logic [31:0] rd);
        at = -1;
        rd = 32'h0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (ready[i] === 1'b1) begin
                at = cyc;
                rd = rdata[i];
                break;
            end
        end
        if (at < 0) check_eq($sformatf("timeout_%0d", i), {31'b0, ready[i]}, 32'd1);
        valid[i] = 1'b0;
        instr[i] = 1'b0;
        wstrb[i] = 4'h0;
    endtask

    task automatic req(input int i, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input logic ins,
                       output int at, output logic [31:0] rd);
        issue(i, a, wd, ws, ins, 1'b1);
        finish_req(i, at, rd);
    endtask

    initial begin : main
        int          t1, t2;
        logic [31:0] rd;
        reset    = 1'b1;
        valid    = '0;
        instr    = '0;
        ld_valid = '0;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0; wdata[i] = '0; wstrb[i] = '0; ld_addr[i] = '0; ld_data[i] = '0;
        end
        repeat (3) @(negedge clock);
        check_eq("rst_ready", {30'b0, ready}, 32'd0);
        check_eq("rst_fault", {30'b0, fault}, 32'd0);
        check_eq("rst_rdata0", rdata[0], 32'd0);
        check_eq("rst_rdata3", rdata[1], 32'd0);
        reset = 1'b0;

        preload(0, 0, 32'h1111_2222);
        preload(0, 1, 32'h3333_4444);
        preload(0, 5, 32'h0000_0000);
        preload(0, NW - 1, 32'hDEAD_BEEF);
        preload(1, 0, 32'h1111_2222);
        preload(1, 1, 32'h3333_4444);
        preload(1, 7, 32'h7777_0007);

        req(0, BASE + 0, 0, 4'h0, 1'b0, t1, rd);
        check_eq("aligned_read", rd, 32'h1111_2222);
        req(0, BASE + 2, 0, 4'h0, 1'b1, t1, rd);
        check_eq("halfword_fetch", rd, 32'h4444_1111);

        req(0, BASE + 20, 32'hAABB_CCDD, 4'b0101, 1'b0, t1, rd);
        req(0, BASE + 20, 0, 4'h0, 1'b0, t2, rd);
        check_eq("strobe_write", rd, 32'h00BB_00DD);
        check_eq("b2b_gap", t2 - t1, 32'd3);

        req(0, BASE + 1, 0, 4'h0, 1'b0, t1, rd);
        req(0, BASE + 2, 32'hFFFF_FFFF, 4'hF, 1'b0, t1, rd);
        req(0, BASE + 32'(4 * NW) - 2, 0, 4'h0, 1'b1, t1, rd);
        req(0, BASE + 32'(4 * NW), 0, 4'h0, 1'b0, t1, rd);
        req(0, BASE + 32'(4 * NW), 32'h5555_5555, 4'hF, 1'b0, t1, rd);
        req(0, BASE + 0, 0, 4'h0, 1'b0, t1, rd);
        check_eq("after_fault_w0", rd, 32'h1111_2222);
        req(0, BASE + 32'(4 * NW) - 4, 0, 4'h0, 1'b0, t1, rd);
        check_eq("last_word", rd, 32'hDEAD_BEEF);

        req(1, BASE + 0, 0, 4'h0, 1'b0, t1, rd);
        check_eq("wait3_aligned", rd, 32'h1111_2222);
        req(1, BASE + 2, 0, 4'h0, 1'b1, t1, rd);
        check_eq("wait3_halfword", rd, 32'h4444_1111);

        issue(0, BASE + 2, 0, 4'h0, 1'b1, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_eq("abort_ready", {31'b0, ready[0]}, 32'd0);
        check_eq("abort_rdata", rdata[0], 32'd0);
        check_eq("abort_fault", {31'b0, fault[0]}, 32'd0);
        valid[0] = 1'b0;
        instr[0] = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check_eq("abort_no_pulse", {31'b0, ready[0]}, 32'd0);
        end
        req(0, BASE + 4, 0, 4'h0, 1'b0, t1, rd);
        check_eq("after_reset_read", rd, 32'h3333_4444);

        issue(1, BASE + 28, 0, 4'h0, 1'b0, 1'b1);
        @(negedge clock);
        ld_valid[1] = 1'b1;
        ld_addr[1]  = 10'd7;
        ld_data[1]  = 32'h0BAD_0BAD;
        @(negedge clock);
        ld_valid[1] = 1'b0;
        finish_req(1, t1, rd);
        check_eq("ld_in_wait_read", rd, 32'h7777_0007);
        req(1, BASE + 28, 0, 4'h0, 1'b0, t1, rd);
        check_eq("ld_in_wait_ram", rd, 32'h7777_0007);

        repeat (2) @(negedge clock);
        check_eq("queue0_empty", q0.size(), 32'd0);
        check_eq("queue3_empty", q1.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
